// File: rtl/ppu_core_arbiter.sv
// Round-robin arbiter that shares one combinational posit core between two
// requesters: registers operands, waits a settle window, returns the result.
module ppu_core_arbiter #(
  parameter int N       = 16,
  parameter int OP_SIZE = 3,
  parameter int TAG_W   = 4,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [N-1:0]       req0_p1,
  input  logic [N-1:0]       req0_p2,
  input  logic [OP_SIZE-1:0] req0_op,
  input  logic [TAG_W-1:0]   req0_tag,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [N-1:0]       req1_p1,
  input  logic [N-1:0]       req1_p2,
  input  logic [OP_SIZE-1:0] req1_op,
  input  logic [TAG_W-1:0]   req1_tag,

  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [N-1:0]       rsp0_pout,
  output logic [TAG_W-1:0]   rsp0_tag,

  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [N-1:0]       rsp1_pout,
  output logic [TAG_W-1:0]   rsp1_tag,

  output logic [N-1:0]       core_p1,
  output logic [N-1:0]       core_p2,
  output logic [OP_SIZE-1:0] core_op,
  input  logic [N-1:0]       core_pout,

  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic             last_served;
  logic             owner;
  logic [TAG_W-1:0] tag_q;
  logic             grant;
  logic             accept;
  logic             rsp_ack;

  // Grant goes to the sole valid requester, or away from last_served on a tie.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_served;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    accept  = (state == IDLE) && (grant ? req1_valid : req0_valid);
    rsp_ack = owner ? rsp1_ready : rsp0_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = ISSUE;
      ISSUE:   if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ack)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && !grant;
    req1_ready = (state == IDLE) &&  grant;
    busy       = (state != IDLE);
  end

  // Core operands stay put after completion; only the next accept reloads them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_served <= 1'b1;
      owner       <= 1'b0;
      tag_q       <= '0;
      core_p1     <= '0;
      core_p2     <= '0;
      core_op     <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_pout   <= '0;
      rsp0_tag    <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_pout   <= '0;
      rsp1_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            core_p1     <= grant ? req1_p1  : req0_p1;
            core_p2     <= grant ? req1_p2  : req0_p2;
            core_op     <= grant ? req1_op  : req0_op;
            tag_q       <= grant ? req1_tag : req0_tag;
            owner       <= grant;
            last_served <= grant;
            cnt         <= CNT_INIT;
          end
        end
        ISSUE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (owner) begin
            rsp1_valid <= 1'b1;
            rsp1_pout  <= core_pout;
            rsp1_tag   <= tag_q;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_pout  <= core_pout;
            rsp0_tag   <= tag_q;
          end
        end
        RESP: begin
          if (rsp_ack) begin
            if (owner) rsp1_valid <= 1'b0;
            else       rsp0_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_core_arbiter.sv
// Bench for ppu_core_arbiter: a behavioural stand-in core drives core_pout,
// and per-channel scoreboards hold expected responses.
module tb_ppu_core_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;

  typedef struct packed {
    logic [15:0] pout;
    logic [3:0]  tag;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with SETTLE=1
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_p1, req0_p2, req1_p1, req1_p2;
  logic [2:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_pout, rsp1_pout;
  logic [3:0]  rsp0_tag, rsp1_tag;
  logic [15:0] core_p1, core_p2, core_pout;
  logic [2:0]  core_op;
  logic        busy;

  // Instance with SETTLE=4
  logic        s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
  logic [15:0] s_req0_p1, s_req0_p2, s_req1_p1, s_req1_p2;
  logic [2:0]  s_req0_op, s_req1_op;
  logic [3:0]  s_req0_tag, s_req1_tag;
  logic        s_rsp0_valid, s_rsp0_ready, s_rsp1_valid, s_rsp1_ready;
  logic [15:0] s_rsp0_pout, s_rsp1_pout;
  logic [3:0]  s_rsp0_tag, s_rsp1_tag;
  logic [15:0] s_core_p1, s_core_p2, s_core_pout;
  logic [2:0]  s_core_op;
  logic        s_busy;

  int   tests_run    = 0;
  int   tests_failed = 0;
  rsp_t q0[$];
  rsp_t q1[$];
  rsp_t qs[$];
  rsp_t exp_r;

  // Stand-in core: known posit results for the directed vectors, NaR propagation,
  // and an arbitrary operand-dependent mix elsewhere.
  function automatic logic [15:0] core_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
    if (op == OP_ADD && a == 16'h4000 && b == 16'h4000) return 16'h5000;
    if (op == OP_MUL && a == 16'h4800 && b == 16'h4800) return 16'h5200;
    return a ^ {b[7:0], b[15:8]} ^ {13'd0, op} ^ 16'h0101;
  endfunction

  assign core_pout   = core_fn(core_p1, core_p2, core_op);
  assign s_core_pout = core_fn(s_core_p1, s_core_p2, s_core_op);

  ppu_core_arbiter #(.N(16), .OP_SIZE(3), .TAG_W(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_p1(req0_p1), .req0_p2(req0_p2),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_p1(req1_p1), .req1_p2(req1_p2),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_pout(rsp0_pout), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_pout(rsp1_pout), .rsp1_tag(rsp1_tag),
    .core_p1(core_p1), .core_p2(core_p2), .core_op(core_op), .core_pout(core_pout),
    .busy(busy)
  );

  ppu_core_arbiter #(.N(16), .OP_SIZE(3), .TAG_W(4), .SETTLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_p1(s_req0_p1), .req0_p2(s_req0_p2),
    .req0_op(s_req0_op), .req0_tag(s_req0_tag),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_p1(s_req1_p1), .req1_p2(s_req1_p2),
    .req1_op(s_req1_op), .req1_tag(s_req1_tag),
    .rsp0_valid(s_rsp0_valid), .rsp0_ready(s_rsp0_ready), .rsp0_pout(s_rsp0_pout), .rsp0_tag(s_rsp0_tag),
    .rsp1_valid(s_rsp1_valid), .rsp1_ready(s_rsp1_ready), .rsp1_pout(s_rsp1_pout), .rsp1_tag(s_rsp1_tag),
    .core_p1(s_core_p1), .core_p2(s_core_p2), .core_op(s_core_op), .core_pout(s_core_pout),
    .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_p1 = '0; req0_p2 = '0; req0_op = '0; req0_tag = '0;
    req1_p1 = '0; req1_p2 = '0; req1_op = '0; req1_tag = '0;
    s_req0_valid = 1'b0; s_req1_valid = 1'b0; s_rsp0_ready = 1'b1; s_rsp1_ready = 1'b1;
    s_req0_p1 = '0; s_req0_p2 = '0; s_req0_op = '0; s_req0_tag = '0;
    s_req1_p1 = '0; s_req1_p2 = '0; s_req1_op = '0; s_req1_tag = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    tests_run++; if ({core_p1, core_p2, core_op} !== 35'd0) begin tests_failed++; $display("FAIL reset_core: got %h %h %h want 0", core_p1, core_p2, core_op); end
    tests_run++; if ({rsp0_pout, rsp0_tag, rsp1_pout, rsp1_tag} !== 40'd0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h %h %h %h want 0", rsp0_pout, rsp0_tag, rsp1_pout, rsp1_tag); end
    rst_n = 1'b1;
    // Both valid after reset: requester 0 must win, but withdraw before the edge
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL reset_first_grant: got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    idle_inputs();
    req0_p1 = 16'h4000; req0_p2 = 16'h4000; req0_op = OP_ADD; req0_tag = 4'd3; req0_valid = 1'b1;
    #1;
    tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    q0.push_back('{pout: 16'h5000, tag: 4'd3});
    tick();
    req0_valid = 1'b0;
    tests_run++; if ({rsp0_valid, busy} !== 2'b01) begin tests_failed++; $display("FAIL single_issue: got valid/busy %b want 01", {rsp0_valid, busy}); end
    tick();
    tests_run++; if (rsp0_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency: rsp0_valid got %b want 1", rsp0_valid); end
    tests_run++; if (rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL single_other_ch: rsp1_valid got %b want 0", rsp1_valid); end
    tests_run++;
    if (q0.size() == 0) begin tests_failed++; $display("FAIL single_sb: rsp0 seen with empty scoreboard"); end
    else begin
      exp_r = q0.pop_front();
      if (rsp0_pout !== exp_r.pout || rsp0_tag !== exp_r.tag) begin
        tests_failed++; $display("FAIL single_rsp: got %h/%h want %h/%h", rsp0_pout, rsp0_tag, exp_r.pout, exp_r.tag);
      end
    end
    tick();
    tests_run++; if ({busy, rsp0_valid} !== 2'b00) begin tests_failed++; $display("FAIL single_done: got busy/valid %b want 00", {busy, rsp0_valid}); end
  endtask

  task automatic test_contention();
    int   grants = 0;
    int   n_rsp  = 0;
    int   c      = 0;
    logic pend0  = 1'b0;
    logic pend1  = 1'b0;
    int   order [4];
    int   acc_c [4];
    idle_inputs();
    req0_p1 = 16'h4000; req0_p2 = 16'h4000; req0_op = OP_ADD; req0_tag = 4'd1;
    req1_p1 = 16'h4800; req1_p2 = 16'h4800; req1_op = OP_MUL; req1_tag = 4'd8;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    while (n_rsp < 4 && c < 60) begin
      tests_run++; if (req0_ready && req1_ready) begin tests_failed++; $display("FAIL cont_ready_excl: both ready at cycle %0d", c); end
      if (rsp0_valid) begin
        n_rsp++;
        tests_run++;
        if (q0.size() == 0) begin tests_failed++; $display("FAIL cont_sb0: rsp0 seen with empty scoreboard"); end
        else begin
          exp_r = q0.pop_front();
          if (rsp0_pout !== exp_r.pout || rsp0_tag !== exp_r.tag) begin
            tests_failed++; $display("FAIL cont_rsp0: got %h/%h want %h/%h", rsp0_pout, rsp0_tag, exp_r.pout, exp_r.tag);
          end
        end
      end
      if (rsp1_valid) begin
        n_rsp++;
        tests_run++;
        if (q1.size() == 0) begin tests_failed++; $display("FAIL cont_sb1: rsp1 seen with empty scoreboard"); end
        else begin
          exp_r = q1.pop_front();
          if (rsp1_pout !== exp_r.pout || rsp1_tag !== exp_r.tag) begin
            tests_failed++; $display("FAIL cont_rsp1: got %h/%h want %h/%h", rsp1_pout, rsp1_tag, exp_r.pout, exp_r.tag);
          end
        end
      end
      if (grants < 4 && req0_valid && req0_ready) begin
        q0.push_back('{pout: core_fn(req0_p1, req0_p2, req0_op), tag: req0_tag});
        order[grants] = 0; acc_c[grants] = c; grants++; pend0 = 1'b1;
      end else if (grants < 4 && req1_valid && req1_ready) begin
        q1.push_back('{pout: core_fn(req1_p1, req1_p2, req1_op), tag: req1_tag});
        order[grants] = 1; acc_c[grants] = c; grants++; pend1 = 1'b1;
      end
      tick(); c++;
      if (pend0) begin req0_tag = req0_tag + 4'd1; req0_p1 = 16'($urandom); req0_p2 = 16'($urandom); req0_op = OP_SUB; pend0 = 1'b0; end
      if (pend1) begin req1_tag = req1_tag + 4'd1; req1_p1 = 16'($urandom); req1_p2 = 16'($urandom); req1_op = OP_ADD; pend1 = 1'b0; end
      if (grants == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    tests_run++; if (n_rsp != 4 || grants != 4) begin tests_failed++; $display("FAIL cont_count: got %0d grants %0d responses want 4 4", grants, n_rsp); end
    for (int i = 0; i < grants; i++) begin
      tests_run++; if (order[i] != (i % 2)) begin tests_failed++; $display("FAIL cont_order[%0d]: got req%0d want req%0d", i, order[i], i % 2); end
    end
    for (int i = 1; i < grants; i++) begin
      tests_run++; if (acc_c[i] - acc_c[i-1] != 3) begin tests_failed++; $display("FAIL cont_spacing[%0d]: got %0d want 3", i, acc_c[i] - acc_c[i-1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held_pout;
    logic [3:0]  held_tag;
    idle_inputs();
    rsp1_ready = 1'b0;
    req1_p1 = 16'h1234; req1_p2 = 16'h0567; req1_op = OP_SUB; req1_tag = 4'd9; req1_valid = 1'b1;
    #1;
    tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept: req1_ready got %b want 1", req1_ready); end
    q1.push_back('{pout: core_fn(16'h1234, 16'h0567, OP_SUB), tag: 4'd9});
    tick();
    req1_valid = 1'b0;
    req0_p1 = 16'h4000; req0_p2 = 16'h4000; req0_op = OP_ADD; req0_tag = 4'd5; req0_valid = 1'b1;
    for (int i = 0; i < 10 && !rsp1_valid; i++) begin
      tests_run++; if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_issue_ready0: got %b want 0", req0_ready); end
      tick();
    end
    tests_run++; if (rsp1_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_timeout: rsp1_valid got %b want 1", rsp1_valid); end
    tests_run++;
    if (q1.size() == 0) begin tests_failed++; $display("FAIL bp_sb: rsp1 seen with empty scoreboard"); end
    else begin
      exp_r = q1.pop_front();
      if (rsp1_pout !== exp_r.pout || rsp1_tag !== exp_r.tag) begin
        tests_failed++; $display("FAIL bp_rsp: got %h/%h want %h/%h", rsp1_pout, rsp1_tag, exp_r.pout, exp_r.tag);
      end
    end
    held_pout = rsp1_pout; held_tag = rsp1_tag;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (rsp1_valid !== 1'b1 || rsp1_pout !== held_pout || rsp1_tag !== held_tag || req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v=%b p=%h t=%h r0=%b v0=%b want 1 %h %h 0 0", i, rsp1_valid, rsp1_pout, rsp1_tag, req0_ready, rsp0_valid, held_pout, held_tag);
      end
    end
    rsp1_ready = 1'b1;
    q0.push_back('{pout: 16'h5000, tag: 4'd5});
    tick();
    tests_run++; if ({busy, rsp1_valid, req0_ready} !== 3'b001) begin tests_failed++; $display("FAIL bp_release: got busy/v1/r0 %b want 001", {busy, rsp1_valid, req0_ready}); end
    tick();
    req0_valid = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_resume: busy got %b want 1", busy); end
    for (int i = 0; i < 10 && !rsp0_valid; i++) tick();
    tests_run++;
    if (rsp0_valid !== 1'b1 || q0.size() == 0) begin tests_failed++; $display("FAIL bp_rsp0: valid %b queued %0d want 1 1", rsp0_valid, q0.size()); end
    else begin
      exp_r = q0.pop_front();
      if (rsp0_pout !== exp_r.pout || rsp0_tag !== exp_r.tag) begin
        tests_failed++; $display("FAIL bp_rsp0_data: got %h/%h want %h/%h", rsp0_pout, rsp0_tag, exp_r.pout, exp_r.tag);
      end
    end
    tick();
  endtask

  task automatic test_settle();
    idle_inputs();
    s_req0_p1 = 16'h4800; s_req0_p2 = 16'h4800; s_req0_op = OP_MUL; s_req0_tag = 4'd7; s_req0_valid = 1'b1;
    #1;
    tests_run++; if (s_req0_ready !== 1'b1) begin tests_failed++; $display("FAIL settle_ready: got %b want 1", s_req0_ready); end
    qs.push_back('{pout: 16'h5200, tag: 4'd7});
    tick();
    s_req0_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (s_core_p1 !== 16'h4800 || s_core_p2 !== 16'h4800 || s_core_op !== OP_MUL || s_rsp0_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL settle_hold[%0d]: got %h %h %h v=%b want 4800 4800 %h 0", i, s_core_p1, s_core_p2, s_core_op, s_rsp0_valid, OP_MUL);
      end
      tick();
    end
    tests_run++; if (s_rsp0_valid !== 1'b1) begin tests_failed++; $display("FAIL settle_latency: rsp0_valid got %b want 1", s_rsp0_valid); end
    tests_run++;
    if (qs.size() == 0) begin tests_failed++; $display("FAIL settle_sb: empty scoreboard"); end
    else begin
      exp_r = qs.pop_front();
      if (s_rsp0_pout !== exp_r.pout || s_rsp0_tag !== exp_r.tag) begin
        tests_failed++; $display("FAIL settle_rsp: got %h/%h want %h/%h", s_rsp0_pout, s_rsp0_tag, exp_r.pout, exp_r.tag);
      end
    end
    tick();
    tests_run++; if ({s_busy, s_core_p1} !== {1'b0, 16'h4800}) begin tests_failed++; $display("FAIL settle_done: busy %b core_p1 %h want 0 4800", s_busy, s_core_p1); end
  endtask

  task automatic test_reset_mid_issue();
    idle_inputs();
    s_req0_p1 = 16'h4000; s_req0_p2 = 16'h4000; s_req0_op = OP_ADD; s_req0_tag = 4'd2; s_req0_valid = 1'b1;
    tick();
    s_req0_valid = 1'b0;
    tick();
    tests_run++; if (s_busy !== 1'b1) begin tests_failed++; $display("FAIL rmid_busy: got %b want 1", s_busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++; if ({s_busy, s_rsp0_valid, s_rsp1_valid} !== 3'b000) begin tests_failed++; $display("FAIL rmid_state: busy/v0/v1 got %b want 000", {s_busy, s_rsp0_valid, s_rsp1_valid}); end
    tests_run++; if ({s_core_p1, s_core_p2, s_core_op} !== 35'd0) begin tests_failed++; $display("FAIL rmid_core: got %h %h %h want 0", s_core_p1, s_core_p2, s_core_op); end
    s_req0_valid = 1'b1; s_req1_valid = 1'b1;
    #1;
    tests_run++; if ({s_req0_ready, s_req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL rmid_grant: got %b want 10", {s_req0_ready, s_req1_ready}); end
    s_req0_valid = 1'b0; s_req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++; if ({s_rsp0_valid, s_rsp1_valid, s_busy} !== 3'b000) begin tests_failed++; $display("FAIL rmid_silent[%0d]: v0/v1/busy got %b want 000", i, {s_rsp0_valid, s_rsp1_valid, s_busy}); end
    end
  endtask

  task automatic test_special();
    idle_inputs();
    req1_p1 = 16'h8000; req1_p2 = 16'h4000; req1_op = OP_ADD; req1_tag = 4'hA; req1_valid = 1'b1;
    #1;
    q1.push_back('{pout: 16'h8000, tag: 4'hA});
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 10 && !rsp1_valid; i++) begin
      tests_run++; if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL special_other_ch: rsp0_valid got %b want 0", rsp0_valid); end
      tick();
    end
    tests_run++;
    if (rsp1_valid !== 1'b1 || q1.size() == 0) begin tests_failed++; $display("FAIL special_timeout: valid %b queued %0d want 1 1", rsp1_valid, q1.size()); end
    else begin
      exp_r = q1.pop_front();
      if (rsp1_pout !== exp_r.pout || rsp1_tag !== exp_r.tag) begin
        tests_failed++; $display("FAIL special_rsp: got %h/%h want %h/%h", rsp1_pout, rsp1_tag, exp_r.pout, exp_r.tag);
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_settle();
    test_reset_mid_issue();
    test_special();
    tests_run++;
    if (q0.size() + q1.size() + qs.size() != 0) begin
      tests_failed++; $display("FAIL sb_drain: got %0d outstanding want 0", q0.size() + q1.size() + qs.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ppu_core_arbiter.md
Name: ppu_core_arbiter

Overview:
Shares one combinational ppu_core_ops instance between two independent requesters. Each requester has its own valid/ready request channel and response channel. The block grants requests round-robin and registers the operands onto the core inputs. It holds them for a programmable settle window, captures the core result, then returns it on the granting requester's response channel. Operations are serialised: at most one is in flight at a time.

Parameters:
N, 16, posit width; must match the attached core.
OP_SIZE, 3, opcode width; must match the core's op port.
TAG_W, 4, requester-side transaction tag width; the tag is returned unchanged with the result.
SETTLE, 1, cycles core inputs are held stable before capture; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_p1  in  N  operand 1.
req0_p2  in  N  operand 2.
req0_op  in  OP_SIZE  opcode.
req0_tag  in  TAG_W  transaction tag.
req1_valid, req1_ready, req1_p1, req1_p2, req1_op, req1_tag: same as requester 0.
rsp0_valid  out  1  result for requester 0 is available.
rsp0_ready  in  1  requester 0 takes the result.
rsp0_pout  out  N  result posit.
rsp0_tag  out  TAG_W  tag of the accepted request.
rsp1_valid, rsp1_ready, rsp1_pout, rsp1_tag: same as requester 0.
core_p1  out  N  registered operand 1 to the core.
core_p2  out  N  registered operand 2 to the core.
core_op  out  OP_SIZE  registered opcode to the core.
core_pout  in  N  core result (combinational from core_*).
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous: when rst_n=0 at a rising edge, the state goes to IDLE and the settle counter to 0.
- Reset values: last_served=1 (so requester 0 wins first), core_p1/core_p2/core_op=0, all rsp_*_pout and rsp_*_tag=0, rsp0_valid=rsp1_valid=0.
- Reset mid-operation aborts the transaction silently: no response is issued and the captured data is discarded.
- The FSM has three states: IDLE, ISSUE, RESP.
- IDLE, grant selection (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_served is granted.
  - req_i_ready = (state==IDLE) && grant==i. Ready may depend on the valids; it never depends on rsp_*_ready. The two ready signals are never high together.
- IDLE, on an accept edge (valid&ready):
  - Load core_p1/core_p2/core_op from the granted requester; latch its tag and index (owner).
  - Set last_served=owner and cnt=SETTLE-1; go to ISSUE.
- ISSUE:
  - core_* are held constant.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture core_pout into rsp_owner_pout and the tag into rsp_owner_tag, set rsp_owner_valid=1, go to RESP.
- RESP:
  - rsp_owner_valid stays high, with pout and tag stable, until rsp_owner_ready=1.
  - On that edge, clear valid and go to IDLE. No new request is accepted in RESP.
  - The other response channel remains 0 throughout.
- Latency: with SETTLE=S, rsp_valid is first high S+1 cycles after the accept cycle. With an always-ready consumer, throughput is one operation per S+2 cycles.
- core_* values persist after completion (they are not cleared) until the next accept.
- Inputs on a non-granted requester are ignored. Its valid may stay high indefinitely, and it wins the next IDLE arbitration.
- Special/trivial posit cases (zero, NaR) need no arbiter handling; the core resolves them, and the arbiter passes core_pout through untouched.

Test Plan:
- Single op: N=16, SETTLE=1, req0 p1=0x4000, p2=0x4000, op=ADD, tag=3, rsp0_ready=1 → rsp0_valid 2 cycles after accept, rsp0_pout=0x5000, rsp0_tag=3; rsp1_valid stays 0.
- Contention: req0 and req1 valid from reset, both always-ready → grants in order req0, req1, req0, req1. Each response is on the correct channel with the matching tag, and the two ready signals are never high together.
- Backpressure: hold rsp1_ready=0 for 5 cycles → rsp1_valid, pout and tag stay constant; req0_ready stays 0 meanwhile. After rsp1_ready=1, IDLE and accept resume the next cycle.
- Settle timing: SETTLE=4, req0 MUL 0x4800×0x4800 → core_* stable for 4 cycles, rsp0_valid in the 5th cycle after accept, pout=0x5200 (2.25).
- Reset mid-ISSUE: assert rst_n=0 for one edge while busy=1 → next cycle busy=0, rsp valids=0, core_*=0, and requester 0 is granted first afterwards.
- Special values: req1 p1=0x8000 (NaR), p2=0x4000, ADD → rsp1_pout=0x8000.
